// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, frame width
// and the clocks-per-bit helper.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT_HIGH
   } uart_state_t;

   localparam int DATA_BITS = 8;

   function automatic int baud_cnt_max(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchroniser for one asynchronous bit, plus a history flop for
// falling-edge detection. All flops reset high so an idle line never looks like an edge.
module uart_bit_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_sync,
   output logic o_fall
);

   logic r_s1;
   logic r_s2;
   logic r_s3;

   always_ff @(posedge i_clk) begin
      // NOTE: non-blocking assignments make the three flops shift one stage per
      // clock; blocking ones would collapse the chain into a single flop.
      if (i_rst) begin
         r_s1 <= 1'b1;
         r_s2 <= 1'b1;
         r_s3 <= 1'b1;
      end else begin
         r_s1 <= i_async;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign o_sync = r_s2;
   assign o_fall = r_s3 & ~r_s2;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit validation at mid-bit, LSB-first data sampling
// at bit centres, stop-bit check with a one-cycle data strobe or framing-error pulse.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ     = 50_000_000,
   parameter int BAUD         = 9600,
   parameter int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, BAUD)
) (
   input  logic                 s_clk,
   input  logic                 s_rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] po_data,
   output logic                 po_flag,
   output logic                 frame_err
);

   localparam int CW = $clog2(BAUD_CNT_MAX);
   localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_CNT_MAX / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_CNT_MAX - 1);
   localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

   logic w_rx;
   logic w_start_edge;

   uart_state_t          r_state;
   logic [CW-1:0]        r_baud_cnt;
   logic [2:0]           r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift_reg;
   logic [DATA_BITS-1:0] r_po_data;
   logic                 r_po_flag;
   logic                 r_frame_err;

   uart_bit_sync u_sync (
      .i_clk   (s_clk),
      .i_rst   (s_rst),
      .i_async (rx),
      .o_sync  (w_rx),
      .o_fall  (w_start_edge)
   );

   always_ff @(posedge s_clk) begin
      if (s_rst) begin
         r_state     <= ST_IDLE;
         r_baud_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_shift_reg <= '0;
         r_po_data   <= '0;
         r_po_flag   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         // Strobes default low so each asserts for exactly one cycle.
         r_po_flag   <= 1'b0;
         r_frame_err <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               r_baud_cnt <= '0;
               r_bit_cnt  <= '0;
               if (w_start_edge) r_state <= ST_START;
            end

            ST_START: begin
               if (r_baud_cnt == HALF_M1) begin
                  r_baud_cnt <= '0;
                  r_state    <= w_rx ? ST_IDLE : ST_DATA;
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end

            ST_DATA: begin
               if (r_baud_cnt == FULL_M1) begin
                  r_baud_cnt  <= '0;
                  r_shift_reg <= {w_rx, r_shift_reg[DATA_BITS-1:1]};
                  r_bit_cnt   <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == LAST_BIT) r_state <= ST_STOP;
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end

            ST_STOP: begin
               if (r_baud_cnt == FULL_M1) begin
                  r_baud_cnt <= '0;
                  if (w_rx) begin
                     r_po_data <= r_shift_reg;
                     r_po_flag <= 1'b1;
                     r_state   <= ST_IDLE;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= ST_WAIT_HIGH;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end

            ST_WAIT_HIGH: begin
               if (w_rx) r_state <= ST_IDLE;
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign po_data   = r_po_data;
   assign po_flag   = r_po_flag;
   assign frame_err = r_frame_err;

endmodule
